// File: rtl/and_1_bit.sv
// and_1_bit: a 1-bit AND gate with a registered copy of the result, a
// rising-edge pulse on that registered copy, and a saturating count of the
// clock edges at which the AND result was high.
//
// X is pure combinational logic. Only X_q, X_rise and hi_count hold state.
// The registered outputs are forced to zero by the asynchronous active-low
// reset. The synchronous clear acts on hi_count only.

module and_1_bit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A,
    input  logic             B,
    input  logic             clr,
    output logic             X,
    output logic             X_q,
    output logic             X_rise,
    output logic [CNT_W-1:0] hi_count
);

    // The counter width is meaningful only from 1 to 32 bits.
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        cnt_w_out_of_range_1_to_32 u_bad_param ();
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             w_x;
    logic             w_cnt_at_max;
    logic             r_x_q;
    logic             r_x_rise;
    logic [CNT_W-1:0] r_hi_count;

    // The 4-state '&' already returns 0 when either operand is 0, even if the
    // other operand is X or Z. So the output is unknown only when no input is 0.
    assign w_x          = A & B;
    assign w_cnt_at_max = (r_hi_count == CNT_MAX);

    // Registered copy of the result and its 0->1 edge detect.
    // The edge detect compares the new sample with the pre-edge X_q, so
    // X_rise is high only in the cycle where X_q first becomes 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_q    <= 1'b0;
            r_x_rise <= 1'b0;
        end else begin
            r_x_q    <= w_x;
            r_x_rise <= w_x & ~r_x_q;
        end
    end

    // Saturating count of the edges at which X was sampled high.
    // clr takes priority over the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_count <= '0;
        end else if (clr) begin
            r_hi_count <= '0;
        end else if (w_x && !w_cnt_at_max) begin
            r_hi_count <= r_hi_count + 1'b1;
        end
    end

    assign X        = w_x;
    assign X_q      = r_x_q;
    assign X_rise   = r_x_rise;
    assign hi_count = r_hi_count;

endmodule

// File: tb/tb_and_1_bit.sv
// Directed testbench for and_1_bit.
// Two instances share the same stimulus:
//   - a narrow counter (CNT_W=3), used to reach saturation quickly;
//   - the default 8-bit counter, which must not saturate at 7.
module tb_and_1_bit;

    logic       clk;
    logic       rst_n;
    logic       A;
    logic       B;
    logic       clr;

    logic       x_3, x_q_3, x_rise_3;
    logic [2:0] hi_count_3;
    logic       x_8, x_q_8, x_rise_8;
    logic [7:0] hi_count_8;

    int checks   = 0;
    int failures = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    and_1_bit #(.CNT_W(3)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .clr      (clr),
        .X        (x_3),
        .X_q      (x_q_3),
        .X_rise   (x_rise_3),
        .hi_count (hi_count_3)
    );

    and_1_bit dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .clr      (clr),
        .X        (x_8),
        .X_q      (x_q_8),
        .X_rise   (x_rise_8),
        .hi_count (hi_count_8)
    );

    // ---------------- helpers ----------------
    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Check the registered outputs of both instances.
    task automatic chk_regs(input string tag, input logic exp_q, input logic exp_rise,
                            input int exp_c3, input int exp_c8);
        chk_bit({tag, ".x_q3"},    x_q_3,    exp_q);
        chk_bit({tag, ".x_q8"},    x_q_8,    exp_q);
        chk_bit({tag, ".rise3"},   x_rise_3, exp_rise);
        chk_bit({tag, ".rise8"},   x_rise_8, exp_rise);
        chk_cnt({tag, ".cnt3"},    32'(hi_count_3), 32'(exp_c3));
        chk_cnt({tag, ".cnt8"},    32'(hi_count_8), 32'(exp_c8));
    endtask

    // ---------------- directed sequence ----------------
    logic [1:0] tt_in;
    logic       b_unk;

    initial begin
        rst_n = 1'b0;
        A     = 1'b0;
        B     = 1'b0;
        clr   = 1'b0;
        #1;
        chk_regs("reset_state", 1'b0, 1'b0, 0, 0);

        // Truth table, applied while still in reset: X must still follow A&B.
        for (int i = 0; i < 4; i++) begin
            tt_in = 2'(i);
            A = tt_in[1];
            B = tt_in[0];
            #1;
            chk_bit($sformatf("truth_%0d%0d.x3", A, B), x_3, (i == 3) ? 1'b1 : 1'b0);
            chk_bit($sformatf("truth_%0d%0d.x8", A, B), x_8, (i == 3) ? 1'b1 : 1'b0);
        end
        tick();
        chk_regs("held_in_reset", 1'b0, 1'b0, 0, 0);

        // Release reset with A=B=1 held.
        rst_n = 1'b1;
        A = 1'b1;
        B = 1'b1;
        tick();
        chk_regs("run_edge1", 1'b1, 1'b1, 1, 1);
        tick();
        chk_regs("run_edge2", 1'b1, 1'b0, 2, 2);
        tick();
        chk_regs("run_edge3", 1'b1, 1'b0, 3, 3);
        // 7 more edges (10 in total): the 3-bit counter stops at 7.
        for (int i = 0; i < 7; i++) tick();
        chk_regs("saturated", 1'b1, 1'b0, 7, 10);
        tick();
        chk_regs("sat_hold", 1'b1, 1'b0, 7, 11);

        // clr while X=1: clr wins, and X_q and X_rise are not affected.
        clr = 1'b1;
        tick();
        chk_regs("clr_wins", 1'b1, 1'b0, 0, 0);
        chk_bit("clr_keeps_x", x_3, 1'b1);
        clr = 1'b0;

        // Count up to 5, then assert reset asynchronously between edges.
        for (int i = 0; i < 5; i++) tick();
        chk_regs("pre_async", 1'b1, 1'b0, 5, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_regs("async_rst", 1'b0, 1'b0, 0, 0);
        chk_bit("async_rst_x", x_3, 1'b1);

        // Release reset with X=1: the first edge gives a rise, because X_q was 0.
        tick();
        rst_n = 1'b1;
        tick();
        chk_regs("post_rst_rise", 1'b1, 1'b1, 1, 1);
        // Reset while X_rise is high.
        #2;
        rst_n = 1'b0;
        #1;
        chk_regs("rst_during_rise", 1'b0, 1'b0, 0, 0);
        tick();
        rst_n = 1'b1;

        // Toggle X 0,1,0,1 on consecutive edges, then hold it at 1.
        A = 1'b0;
        tick();
        chk_regs("tog_0", 1'b0, 1'b0, 0, 0);
        A = 1'b1;
        tick();
        chk_regs("tog_1", 1'b1, 1'b1, 1, 1);
        A = 1'b0;
        tick();
        chk_regs("tog_2", 1'b0, 1'b0, 1, 1);
        A = 1'b1;
        tick();
        chk_regs("tog_3", 1'b1, 1'b1, 2, 2);
        tick();
        chk_regs("tog_hold", 1'b1, 1'b0, 3, 3);
        A = 1'b0;
        tick();
        chk_regs("tog_fall", 1'b0, 1'b0, 3, 3);

        // Unknown operand: a 0 on the other input forces 0. Otherwise the
        // result follows the unknown value.
        b_unk = 1'bz;
        A = 1'b0;
        B = b_unk;
        #1;
        chk_bit("unk_a0_bz", x_3, 1'b0);
        b_unk = 1'bx;
        B = b_unk;
        #1;
        chk_bit("unk_a0_bx", x_8, 1'b0);
        A = 1'b1;
        #1;
        chk_bit("unk_a1_bx", x_3, 1'b1 & b_unk);
        b_unk = 1'bz;
        B = b_unk;
        #1;
        chk_bit("unk_a1_bz", x_8, 1'b1 & b_unk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/and_1_bit.md
AND_1_BIT -- requirements
Module: and_1_bit

Interface
Parameters:
REQ-001 The block SHALL have parameter CNT_W, default 8: width of the high-cycle counter, legal range 1..32.

Ports:
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port A, input, 1 bit: first operand.
REQ-005 The block SHALL have port B, input, 1 bit: second operand.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous clear of hi_count, active-high.
REQ-007 The block SHALL have port X, output, 1 bit: combinational logical AND of A and B.
REQ-008 The block SHALL have port X_q, output, 1 bit: X registered once on clk.
REQ-009 The block SHALL have port X_rise, output, 1 bit: one-cycle pulse on a 0->1 transition of the registered result.
REQ-010 The block SHALL have port hi_count, output, CNT_W bits: saturating count of clock edges at which X was sampled 1.

Function
REQ-011 X SHALL equal A AND B combinationally, with zero clock latency: 00->0, 01->0, 10->0, 11->1.
REQ-012 X SHALL be independent of clk, rst_n and clr.
REQ-013 X SHALL be 0 whenever either input is 0, even if the other input is X/Z.
REQ-014 X SHALL be unknown only when neither input is 0 and at least one input is unknown.
REQ-015 At each rising clk edge with rst_n high, X_q SHALL take the value of X, giving one cycle of latency.
REQ-016 At each rising clk edge with rst_n high, X_rise SHALL be loaded with X AND NOT X_q, using the pre-edge X_q.
REQ-017 As a consequence of REQ-016, X_rise SHALL be high for exactly the one cycle in which X_q first goes 1.
REQ-018 X_rise SHALL NOT re-assert while X stays 1.
REQ-019 X_rise SHALL NOT assert on a 1->0 transition of X.
REQ-020 At each rising clk edge with rst_n high and clr=0, hi_count SHALL increment by 1 if X=1 and hold if X=0.
REQ-021 hi_count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap to 0.
REQ-022 At a rising edge with clr=1, hi_count SHALL become 0.
REQ-023 clr SHALL take priority over a simultaneous increment.
REQ-024 clr SHALL NOT affect X, X_q or X_rise.
REQ-025 The block SHALL contain no state other than X_q, X_rise and hi_count.

Reset
REQ-026 While rst_n=0, the outputs SHALL be X_q=0, X_rise=0 and hi_count=0, applied asynchronously without waiting for a clk edge.
REQ-027 X SHALL continue to track A AND B while rst_n=0.
REQ-028 On release of rst_n, the first update SHALL occur at the next rising clk edge.
REQ-029 Following reset release, X_rise SHALL assert if X=1 at that edge, because X_q resets to 0.
REQ-030 Reset asserted mid-operation, including while hi_count is saturated or X_rise is high, SHALL force the reset values immediately.

Verification
REQ-031 Truth table: apply A,B = 00, 01, 10, 11 for one time unit each -> X = 0, 0, 0, 1, each settling within the same time step.
REQ-032 Registered path: with A=B=1 held after reset and clr=0 -> after edge 1, X_q=1 and X_rise=1; after edge 2, X_rise=0; hi_count reaches 1, 2, 3 on successive edges.
REQ-033 Saturation: CNT_W=3, X=1 held for 10 edges -> hi_count reaches 7 and stays 7; with clr=1 at the same edge as X=1 -> hi_count=0.
REQ-034 Async reset: drive rst_n low between edges while hi_count=5 and X_q=1 -> X_q=0, X_rise=0 and hi_count=0 before the next edge, while X remains 1.
REQ-035 Unknown input: A=0, B=X/Z -> X=0; A=1, B=X/Z -> X unknown.
REQ-036 Toggle: X sequence 0,1,0,1 on consecutive edges -> X_rise pulses on the cycles X_q rises only; hi_count=2.
